// File: rtl/modmul_prod_gen_pkg.sv
// Shared constants for the modular-multiply product generator and the
// Barrett reducer it feeds.
//   Q       : modulus, 2^24 - 2^18 + 1
//   Q2      : 2*Q, the reducer's final-correction bound
//   LAT_MUL : cycles from operand accept to product valid
//   LAT_RED : cycles from product valid to reduced word valid
//   N_COEF_W: width of the run-length input
package modmul_prod_gen_pkg;

    localparam logic [23:0] Q        = 24'd16515073;
    localparam logic [24:0] Q2       = 25'd33030146;
    localparam int          LAT_MUL  = 2;
    localparam int          LAT_RED  = 3;
    localparam int          N_COEF_W = 9;

endpackage

// File: rtl/modmul_pipe_mac.sv
// Two-stage a*b + c*d pipeline with its valid delay.
//   clk, rst   : clock, synchronous active-high reset
//   fire_i     : operand set accepted this cycle
//   mode_i     : 0 -> a*b, 1 -> a*b + c*d
//   a_i..d_i   : 24-bit operands
//   prod_o     : 49-bit sum of products, holds when prod_en_o = 0
//   prod_en_o  : prod_o valid, a pure LAT_MUL-cycle delay of fire_i
module modmul_pipe_mac (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire_i,
    input  logic        mode_i,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic [23:0] c_i,
    input  logic [23:0] d_i,
    output logic [48:0] prod_o,
    output logic        prod_en_o
);

    logic [23:0] a_q, b_q, c_q, d_q;
    logic        vld0_q;
    logic [47:0] ab_q, cd_q;
    logic        vld1_q;
    logic [48:0] prod_q;
    logic        vld2_q;

    // The operand register is loaded on the accepting edge itself, so the
    // two multiplier stages land one and two edges after the accept.
    // NOTE: every flop here, data included, is reset so that prod reads 0
    // after reset and an aborted run leaves no stale valid bits behind; all
    // sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            vld0_q    <= 1'b0;
            ab_q      <= '0;
            cd_q      <= '0;
            vld1_q    <= 1'b0;
            prod_q    <= '0;
            vld2_q    <= 1'b0;
        end else begin
            vld0_q <= fire_i;
            vld1_q <= vld0_q;
            vld2_q <= vld1_q;
            if (fire_i) begin
                a_q <= a_i;
                b_q <= b_i;
                // Zeroing c/d in mode 0 makes the c*d term vanish downstream.
                c_q <= mode_i ? c_i : 24'd0;
                d_q <= mode_i ? d_i : 24'd0;
            end
            if (vld0_q) begin
                ab_q <= {24'd0, a_q} * {24'd0, b_q};
                cd_q <= {24'd0, c_q} * {24'd0, d_q};
            end
            if (vld1_q) begin
                prod_q <= {1'b0, ab_q} + {1'b0, cd_q};
            end
        end
    end

    assign prod_o    = prod_q;
    assign prod_en_o = vld2_q;

endmodule

// File: rtl/modmul_prod_gen.sv
// Front-end producer for the 49-bit-input Barrett reducer mod Q.
// Frames a run of coefficients, issues products to the reducer and tracks
// its latency so result-valid, last and done line up with reducer output.
//   clk, rst          : clock, synchronous active-high reset
//   start, n_coef     : begin a run of n_coef sets (0 means 256), IDLE only
//   in_valid/in_ready : operand-set handshake
//   in_mode           : 0 -> a*b, 1 -> a*b + c*d
//   in_a..in_d        : 24-bit operands, expected < Q
//   prod, prod_en     : reducer data input and enable
//   res_valid/res_last: reducer output valid / final coefficient of the run
//   done              : one-cycle pulse once the run has drained
//   range_err         : sticky, an accepted operand was >= Q
//   busy              : not IDLE
module modmul_prod_gen
    import modmul_prod_gen_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_COEF_W-1:0] n_coef,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [23:0]         in_a,
    input  logic [23:0]         in_b,
    input  logic [23:0]         in_c,
    input  logic [23:0]         in_d,
    output logic [48:0]         prod,
    output logic                prod_en,
    output logic                res_valid,
    output logic                res_last,
    output logic                done,
    output logic                range_err,
    output logic                busy
);

    localparam int                  LAT_TOT    = LAT_MUL + LAT_RED;
    localparam logic [2:0]          DRAIN_LOAD = 3'(LAT_TOT);
    localparam logic [N_COEF_W-1:0] RUN_MAX    = N_COEF_W'(256);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [N_COEF_W-1:0] remaining_q;
    logic [2:0]          drain_q;
    logic                range_err_q;
    logic                fin_q;
    logic [LAT_RED-1:0]  rv_q;
    logic [LAT_TOT-1:0]  last_q;

    logic accept;
    logic range_hit_d;

    assign accept = in_valid & in_ready;

    // c and d only contribute in mode 1, so only then are they range-checked.
    assign range_hit_d = (in_a >= Q) | (in_b >= Q)
                       | (in_mode & ((in_c >= Q) | (in_d >= Q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            drain_q     <= '0;
            range_err_q <= 1'b0;
            fin_q       <= 1'b0;
            rv_q        <= '0;
            last_q      <= '0;
        end else begin
            // fin_q marks the final accept on the same edge the operands are
            // captured, so LAT_TOT more stages align it with res_valid.
            fin_q  <= accept && (remaining_q == N_COEF_W'(1));
            rv_q   <= {rv_q[LAT_RED-2:0], prod_en};
            last_q <= {last_q[LAT_TOT-2:0], fin_q};

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        remaining_q <= (n_coef == '0) ? RUN_MAX : n_coef;
                        range_err_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        remaining_q <= remaining_q - N_COEF_W'(1);
                        if (range_hit_d) begin
                            range_err_q <= 1'b1;
                        end
                        if (remaining_q == N_COEF_W'(1)) begin
                            state_q <= S_DRAIN;
                            drain_q <= DRAIN_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q - 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    modmul_pipe_mac u_mac (
        .clk       (clk),
        .rst       (rst),
        .fire_i    (accept),
        .mode_i    (in_mode),
        .a_i       (in_a),
        .b_i       (in_b),
        .c_i       (in_c),
        .d_i       (in_d),
        .prod_o    (prod),
        .prod_en_o (prod_en)
    );

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign range_err = range_err_q;
    assign res_valid = rv_q[LAT_RED-1];
    assign res_last  = last_q[LAT_TOT-1];

endmodule

// File: tb/tb_modmul_prod_gen.sv
module tb_modmul_prod_gen;

    localparam int QM = 16515073;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  n_coef;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [23:0] in_a, in_b, in_c, in_d;
    logic [48:0] prod;
    logic        prod_en;
    logic        res_valid;
    logic        res_last;
    logic        done;
    logic        range_err;
    logic        busy;

    typedef struct {
        logic [48:0] prod;
        int          cyc;
    } pexp_t;

    typedef struct {
        int   cyc;
        logic last;
    } rexp_t;

    pexp_t pq[$];
    rexp_t rq[$];
    pexp_t pe;
    rexp_t re;

    int cyc       = 0;
    int n_checks  = 0;
    int n_pass    = 0;
    int pe_count  = 0;
    int done_seen = 0;
    int run_n     = 0;
    int acc_cnt   = 0;
    int last_acc  = 0;

    modmul_prod_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_coef    (n_coef),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .prod      (prod),
        .prod_en   (prod_en),
        .res_valid (res_valid),
        .res_last  (res_last),
        .done      (done),
        .range_err (range_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge k (and until the next), cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (prod_en) begin
                pe_count++;
                n_checks++;
                if (pq.size() == 0) begin
                    $display("FAIL prod_en_unexpected: prod_en=1 prod=%0d at cycle %0d, none expected", prod, cyc);
                end else begin
                    pe = pq.pop_front();
                    if (prod !== pe.prod || cyc != pe.cyc)
                        $display("FAIL prod_out: got prod=%0d at cycle %0d, expected prod=%0d at cycle %0d",
                                 prod, cyc, pe.prod, pe.cyc);
                    else
                        n_pass++;
                end
            end
            if (res_valid) begin
                n_checks++;
                if (rq.size() == 0) begin
                    $display("FAIL res_valid_unexpected: res_valid=1 at cycle %0d, none expected", cyc);
                end else begin
                    re = rq.pop_front();
                    if (res_last !== re.last || cyc != re.cyc)
                        $display("FAIL res_out: got res_last=%0b at cycle %0d, expected res_last=%0b at cycle %0d",
                                 res_last, cyc, re.last, re.cyc);
                    else
                        n_pass++;
                end
            end else if (res_last) begin
                n_checks++;
                $display("FAIL res_last_stray: res_last=1 without res_valid at cycle %0d, expected 0", cyc);
            end
            if (done) done_seen++;
        end
    end

    task automatic do_start(input int n);
        start  = 1'b1;
        n_coef = n[8:0];
        @(posedge clk);
        #1;
        start   = 1'b0;
        run_n   = (n == 0) ? 256 : n;
        acc_cnt = 0;
    endtask

    // Presents one operand set for one cycle; in_valid is left high so
    // consecutive calls form back-to-back traffic.
    task automatic drive_set(input logic mode, input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] c, input logic [23:0] d, input bit exp_acc);
        logic [48:0] ep;
        in_valid = 1'b1;
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_d     = d;
        if (exp_acc) begin
            ep = 49'(a) * 49'(b) + (mode ? 49'(c) * 49'(d) : 49'd0);
            acc_cnt++;
            last_acc = cyc + 1;
            pq.push_back('{ep, cyc + 3});
            rq.push_back('{cyc + 6, (acc_cnt == run_n)});
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== exp_acc)
            $display("FAIL in_ready: got %0b at cycle %0d, expected %0b", in_ready, cyc, exp_acc);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int exp_edge;
        exp_edge = last_acc + 6;
        in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        n_checks++;
        if (!done)
            $display("FAIL done_timeout: done=0 after 60 cycles, expected pulse at cycle %0d", exp_edge);
        else if (cyc != exp_edge)
            $display("FAIL done_cycle: done at cycle %0d, expected %0d", cyc, exp_edge);
        else
            n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_pulse: done=%0b busy=%0b after pulse, expected 0 0", done, busy);
        else
            n_pass++;
        n_checks++;
        if (pq.size() != 0 || rq.size() != 0)
            $display("FAIL drain_queues: %0d prod / %0d res outstanding, expected 0 0", pq.size(), rq.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        n_coef   = '0;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({in_ready, prod_en, res_valid, res_last, done, range_err, busy} !== 7'b0)
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {in_ready, prod_en, res_valid, res_last, done, range_err, busy});
        else
            n_pass++;
        n_checks++;
        if (prod !== 49'd0)
            $display("FAIL reset_prod: got %0d, expected 0", prod);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int ds0, pe0;
        do_start(4);
        drive_set(1'b0, 24'd11, 24'd12, 24'd0, 24'd0, 1'b1);
        drive_set(1'b0, 24'd13, 24'd14, 24'd0, 24'd0, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pq.delete();
        rq.delete();
        ds0 = done_seen;
        pe0 = pe_count;
        n_checks++;
        if ({in_ready, prod_en, res_valid, res_last, done, range_err, busy} !== 7'b0)
            $display("FAIL midrun_reset_ctrl: got %b, expected 0000000",
                     {in_ready, prod_en, res_valid, res_last, done, range_err, busy});
        else
            n_pass++;
        n_checks++;
        if (prod !== 49'd0)
            $display("FAIL midrun_reset_prod: got %0d, expected 0", prod);
        else
            n_pass++;
        repeat (10) idle_cycle();
        n_checks++;
        if (done_seen != ds0 || pe_count != pe0 || busy !== 1'b0)
            $display("FAIL midrun_quiet: done pulses=%0d prod_en pulses=%0d busy=%0b, expected 0 0 0",
                     done_seen - ds0, pe_count - pe0, busy);
        else
            n_pass++;
        do_start(1);
        drive_set(1'b0, 24'd7, 24'd9, 24'd0, 24'd0, 1'b1);
        wait_done();
    endtask

    task automatic test_mode0_single();
        do_start(1);
        drive_set(1'b0, 24'd3, 24'd5, 24'd100, 24'd200, 1'b1);
        wait_done();
        n_checks++;
        if (prod !== 49'd15 || prod_en !== 1'b0)
            $display("FAIL mode0_hold: got prod=%0d prod_en=%0b, expected 15 0", prod, prod_en);
        else
            n_pass++;
    endtask

    task automatic test_mode1_max();
        longint p;
        do_start(1);
        drive_set(1'b1, 24'(QM - 1), 24'(QM - 1), 24'(QM - 1), 24'(QM - 1), 1'b1);
        wait_done();
        p = longint'(prod);
        n_checks++;
        if (p % longint'(QM) != 64'sd2)
            $display("FAIL mode1_reduced: got %0d, expected 2", p % longint'(QM));
        else
            n_pass++;
        n_checks++;
        if (range_err !== 1'b0)
            $display("FAIL mode1_range: got %0b, expected 0", range_err);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int pe0;
        logic [23:0] ra, rb, rc, rd;
        logic        rm;
        pe0 = pe_count;
        do_start(0);
        for (int i = 0; i < 256; i++) begin
            ra = 24'($urandom_range(0, QM - 1));
            rb = 24'($urandom_range(0, QM - 1));
            rc = 24'($urandom_range(0, QM - 1));
            rd = 24'($urandom_range(0, QM - 1));
            rm = 1'($urandom_range(0, 1));
            drive_set(rm, ra, rb, rc, rd, 1'b1);
        end
        drive_set(1'b0, 24'd1, 24'd1, 24'd0, 24'd0, 1'b0);
        wait_done();
        n_checks++;
        if (pe_count - pe0 != 256)
            $display("FAIL run256_count: got %0d prod_en pulses, expected 256", pe_count - pe0);
        else
            n_pass++;
    endtask

    task automatic test_gapped();
        do_start(3);
        drive_set(1'b1, 24'd1000, 24'd2000, 24'd3000, 24'd4000, 1'b1);
        idle_cycle();
        drive_set(1'b0, 24'd77, 24'd88, 24'd0, 24'd0, 1'b1);
        idle_cycle();
        drive_set(1'b1, 24'd5, 24'd6, 24'd7, 24'd8, 1'b1);
        in_valid = 1'b0;
        start    = 1'b1;
        n_coef   = 9'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL drain_start_ignored: got in_ready=%0b busy=%0b, expected 0 1", in_ready, busy);
        else
            n_pass++;
        wait_done();
    endtask

    task automatic test_range_err();
        do_start(2);
        drive_set(1'b0, 24'd5, 24'd6, 24'(QM), 24'(QM), 1'b1);
        n_checks++;
        if (range_err !== 1'b0)
            $display("FAIL range_mode0_cd: got %0b, expected 0", range_err);
        else
            n_pass++;
        drive_set(1'b0, 24'(QM), 24'd1, 24'd0, 24'd0, 1'b1);
        n_checks++;
        if (range_err !== 1'b1)
            $display("FAIL range_set: got %0b, expected 1", range_err);
        else
            n_pass++;
        wait_done();
        n_checks++;
        if (range_err !== 1'b1)
            $display("FAIL range_sticky: got %0b after done, expected 1", range_err);
        else
            n_pass++;
        do_start(1);
        n_checks++;
        if (range_err !== 1'b0)
            $display("FAIL range_clear: got %0b after start, expected 0", range_err);
        else
            n_pass++;
        drive_set(1'b0, 24'd2, 24'd2, 24'd0, 24'd0, 1'b1);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_mode0_single();
        test_mode1_max();
        test_back_to_back();
        test_gapped();
        test_range_err();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule
